// File: rtl/logic_unit_serial_if.sv
// Operand/result bus shared between the serial logic unit and its requester.
// The requester drives start/op/a/b; the unit answers with busy/done/out/zero.
interface logic_unit_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, out, zero
  );
endinterface

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NAND) that evaluates SLICE bits
// per clock, so only a SLICE-wide gate array is needed for any WIDTH.
// Operands and op are captured on accept; later bus changes are ignored.
module logic_unit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic               clk,
  input logic               rst_n,
  logic_unit_serial_if.slave bus
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [1:0]       op_l;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_res;
  logic [WIDTH-1:0] out_next;

  // Evaluate the current slice only; this is the whole gate array.
  always_comb begin
    sl_a = a_l[int'(idx) * SLICE +: SLICE];
    sl_b = b_l[int'(idx) * SLICE +: SLICE];
    case (op_l)
      OP_AND:  sl_res = sl_a & sl_b;
      OP_OR:   sl_res = sl_a | sl_b;
      OP_XOR:  sl_res = sl_a ^ sl_b;
      default: sl_res = ~(sl_a & sl_b);
    endcase
  end

  // Result as it will look after this edge, so zero can include the last slice.
  always_comb begin
    out_next = out_r;
    out_next[int'(idx) * SLICE +: SLICE] = sl_res;
  end

  // Control FSM plus operand capture and slice-by-slice result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      a_l    <= '0;
      b_l    <= '0;
      op_l   <= OP_AND;
      out_r  <= '0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_l    <= bus.a;
            b_l    <= bus.b;
            op_l   <= bus.op;
            out_r  <= '0;
            zero_r <= 1'b0;
            idx    <= '0;
            state  <= ST_BUSY;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          out_r <= out_next;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            zero_r <= (out_next == '0);
            state  <= ST_DONE;
          end else begin
            idx    <= idx + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_BUSY);
  assign bus.done = (state == ST_DONE);
  assign bus.out  = out_r;
  assign bus.zero = zero_r;

endmodule

// File: tb/tb_logic_unit_serial.sv
// Bench for logic_unit_serial: a 16-bit/4-bit-slice unit and an 8-bit
// single-slice unit, checked against whole-word logic and cycle-count rules.
module tb_logic_unit_serial;

  logic clk = 1'b0;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  logic_unit_serial_if #(.WIDTH(16)) bus16();
  logic_unit_serial_if #(.WIDTH(8))  bus8();

  logic_unit_serial #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  logic_unit_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  // Whole-word reference result of an operation.
  function automatic logic [15:0] golden(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Present an operation with a one-cycle start pulse; returns in the first busy cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus16.op    = op;
    bus16.a     = a;
    bus16.b     = b;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  // Count busy cycles from the current sample onward; stops on the first non-busy sample.
  task automatic wait_done16(output int nbusy, output logic saw_done);
    nbusy = 0;
    while (bus16.busy === 1'b1 && nbusy < 50) begin
      nbusy++;
      @(negedge clk);
    end
    saw_done = bus16.done;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus16.start = 1'b0; bus16.op = 2'b00; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus16.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus16.busy); end
    tests_run++; if (bus16.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b, expected 0", bus16.done); end
    tests_run++; if (bus16.out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_out: got %h, expected 0000", bus16.out); end
    tests_run++; if (bus16.zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_zero: got %b, expected 0", bus16.zero); end
    tests_run++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_narrow: got busy=%b done=%b, expected 0 0", bus8.busy, bus8.done); end
    rst_n = 1'b1;
  endtask

  task automatic test_and;
    int nb; logic sd;
    applyStimulus(2'b00, 16'hF0F0, 16'hFF00);
    wait_done16(nb, sd);
    tests_run++; if (nb !== 4) begin tests_failed++; $display("[TB] FAIL and_busy_cycles: got %0d, expected 4", nb); end
    tests_run++; if (sd !== 1'b1) begin tests_failed++; $display("[TB] FAIL and_done: got %b, expected 1", sd); end
    tests_run++; if (bus16.out !== 16'hF000) begin tests_failed++; $display("[TB] FAIL and_out: got %h, expected F000", bus16.out); end
    tests_run++; if (bus16.zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_zero: got %b, expected 0", bus16.zero); end
    @(negedge clk);
    tests_run++; if (bus16.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_done_width: got %b, expected 0", bus16.done); end
    tests_run++; if (bus16.out !== 16'hF000) begin tests_failed++; $display("[TB] FAIL and_out_hold: got %h, expected F000", bus16.out); end
  endtask

  task automatic test_zero;
    int nb; logic sd;
    applyStimulus(2'b10, 16'h1234, 16'h1234);
    wait_done16(nb, sd);
    tests_run++; if (sd !== 1'b1 || bus16.out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL xor_self: got done=%b out=%h, expected 1 0000", sd, bus16.out); end
    tests_run++; if (bus16.zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL xor_self_zero: got %b, expected 1", bus16.zero); end
    @(negedge clk);
    tests_run++; if (bus16.zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_hold_idle: got %b, expected 1", bus16.zero); end
    applyStimulus(2'b11, 16'hFFFF, 16'hFFFF);
    wait_done16(nb, sd);
    tests_run++; if (sd !== 1'b1 || bus16.out !== 16'h0000) begin tests_failed++; $display("[TB] FAIL nand_ones: got done=%b out=%h, expected 1 0000", sd, bus16.out); end
    tests_run++; if (bus16.zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL nand_ones_zero: got %b, expected 1", bus16.zero); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int nb; int extra; logic sd;
    @(negedge clk);
    bus16.op = 2'b01; bus16.a = 16'h00FF; bus16.b = 16'hFF00; bus16.start = 1'b1;
    @(negedge clk);
    tests_run++; if (bus16.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL or_accept: got busy=%b, expected 1", bus16.busy); end
    bus16.op = 2'b00; bus16.a = 16'h0000; bus16.b = 16'h0000;
    @(negedge clk);
    bus16.start = 1'b0;
    wait_done16(nb, sd);
    tests_run++; if (nb + 1 !== 4) begin tests_failed++; $display("[TB] FAIL or_busy_cycles: got %0d, expected 4", nb + 1); end
    tests_run++; if (sd !== 1'b1 || bus16.out !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL or_latched: got done=%b out=%h, expected 1 FFFF", sd, bus16.out); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.done === 1'b1 || bus16.busy === 1'b1) extra++;
    end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("[TB] FAIL or_single_done: got %0d extra busy/done cycles, expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int nb; logic sd;
    logic [15:0] a1, b1, a2, b2;
    logic [1:0]  op2;
    a1 = 16'($urandom); b1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); op2 = 2'($urandom_range(1, 3));
    @(negedge clk);
    bus16.op = 2'b00; bus16.a = a1; bus16.b = b1; bus16.start = 1'b1;
    @(negedge clk);
    bus16.op = op2; bus16.a = a2; bus16.b = b2;
    wait_done16(nb, sd);
    tests_run++; if (nb !== 4 || sd !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_timing: got busy=%0d done=%b, expected 4 1", nb, sd); end
    tests_run++; if (bus16.out !== golden(2'b00, a1, b1)) begin tests_failed++; $display("[TB] FAIL b2b_first_out: got %h, expected %h", bus16.out, golden(2'b00, a1, b1)); end
    @(negedge clk);
    bus16.start = 1'b0;
    tests_run++; if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_no_gap: got busy=%b done=%b, expected 1 0", bus16.busy, bus16.done); end
    wait_done16(nb, sd);
    tests_run++; if (nb !== 4 || sd !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second_timing: got busy=%0d done=%b, expected 4 1", nb, sd); end
    tests_run++; if (bus16.out !== golden(op2, a2, b2)) begin tests_failed++; $display("[TB] FAIL b2b_second_out: got %h, expected %h", bus16.out, golden(op2, a2, b2)); end
    tests_run++; if (bus16.zero !== (golden(op2, a2, b2) == 16'h0)) begin tests_failed++; $display("[TB] FAIL b2b_second_zero: got %b", bus16.zero); end
    @(negedge clk);
    tests_run++; if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_to_idle: got busy=%b done=%b, expected 0 0", bus16.busy, bus16.done); end
  endtask

  task automatic test_reset_mid;
    int seen;
    applyStimulus(2'b01, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++; if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_ctrl: got busy=%b done=%b, expected 0 0", bus16.busy, bus16.done); end
    tests_run++; if (bus16.out !== 16'h0000 || bus16.zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_data: got out=%h zero=%b, expected 0000 0", bus16.out, bus16.zero); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.done === 1'b1 || bus16.busy === 1'b1) seen++;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL midreset_no_done: got %0d busy/done cycles, expected 0", seen); end
  endtask

  task automatic test_random;
    int nb; logic sd;
    logic [15:0] a, b, exp;
    logic [1:0]  op;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      exp = golden(op, a, b);
      applyStimulus(op, a, b);
      wait_done16(nb, sd);
      tests_run++; if (nb !== 4 || sd !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_timing[%0d]: got busy=%0d done=%b, expected 4 1", i, nb, sd); end
      tests_run++; if (bus16.out !== exp) begin tests_failed++; $display("[TB] FAIL rand_out[%0d]: op=%0d a=%h b=%h got %h, expected %h", i, op, a, b, bus16.out, exp); end
      tests_run++; if (bus16.zero !== (exp == 16'h0)) begin tests_failed++; $display("[TB] FAIL rand_zero[%0d]: got %b, expected %b", i, bus16.zero, (exp == 16'h0)); end
    end
  endtask

  task automatic test_narrow;
    logic [15:0] full;
    logic [7:0]  a, b, exp;
    logic [1:0]  op;
    for (int i = 0; i < 17; i++) begin
      if (i == 0) begin
        op = 2'b00; a = 8'h3C; b = 8'h0F;
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = 8'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      end
      full = golden(op, {8'h00, a}, {8'h00, b});
      exp  = full[7:0];
      @(negedge clk);
      bus8.op = op; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      tests_run++; if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL narrow_busy[%0d]: got busy=%b done=%b, expected 1 0", i, bus8.busy, bus8.done); end
      @(negedge clk);
      tests_run++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL narrow_done[%0d]: got busy=%b done=%b, expected 0 1", i, bus8.busy, bus8.done); end
      tests_run++; if (bus8.out !== exp) begin tests_failed++; $display("[TB] FAIL narrow_out[%0d]: op=%0d a=%h b=%h got %h, expected %h", i, op, a, b, bus8.out, exp); end
      tests_run++; if (bus8.zero !== (exp == 8'h0)) begin tests_failed++; $display("[TB] FAIL narrow_zero[%0d]: got %b, expected %b", i, bus8.zero, (exp == 8'h0)); end
    end
    @(negedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset;
    test_and;
    test_zero;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_narrow;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
